// File: rtl/ctl_disp_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctl_disp_mux_if
//  Brief    : Digit/control inputs and anode/segment outputs of the display mux.
//  Revision : 1.0 - initial release
// ============================================================================
interface ctl_disp_mux_if;
   logic [3:0] hex0;
   logic [3:0] hex1;
   logic [3:0] hex2;
   logic [3:0] hex3;
   logic [3:0] dp_en;
   logic       blank_lz;
   logic       blink;
   logic [3:0] an;
   logic [6:0] sseg;
   logic       dp;

   modport master (
      output hex0, hex1, hex2, hex3, dp_en, blank_lz, blink,
      input  an, sseg, dp
   );

   modport slave (
      input  hex0, hex1, hex2, hex3, dp_en, blank_lz, blink,
      output an, sseg, dp
   );
endinterface
`default_nettype wire

// File: rtl/ctl_disp_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ctl_disp_mux
//  Brief    : 4-digit multiplexed 7-segment driver with tear-free shadowing,
//             leading-zero blanking, per-slot ghost blanking and blinking.
//  Revision : 1.0 - initial release
// ============================================================================
module ctl_disp_mux #(
   parameter int DIV         = 65000,
   parameter int BLANK_CYC   = 64,
   parameter int BLINK_SCANS = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   ctl_disp_mux_if.slave   bus
);

   localparam logic [15:0] c_presc_max = 16'(DIV - 1);
   localparam logic [15:0] c_blank     = 16'(BLANK_CYC);
   localparam logic [7:0]  c_phase_max = 8'(BLINK_SCANS - 1);

   logic [15:0]     r_presc;
   logic [1:0]      r_idx;
   logic [3:0][3:0] r_sh_hex;
   logic [3:0]      r_sh_dp_en;
   logic            r_sh_lz;
   logic            r_sh_blink;
   logic            r_phase_on;
   logic [7:0]      r_phase_cnt;
   logic [3:0]      r_an;
   logic [6:0]      r_sseg;
   logic            r_dp;

   logic            w_slot_tick;
   logic            w_scan_tick;
   logic            w_dark;
   logic            w_lz_blank;
   logic [6:0]      w_seg;

   function automatic logic [6:0] f_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      w_slot_tick = (r_presc == c_presc_max);
      w_scan_tick = w_slot_tick && (r_idx == 2'd3);
      w_dark      = (r_presc < c_blank) || (r_sh_blink && !r_phase_on);
      // Only the two score digits (3 and 2) are candidates for zero suppression.
      w_lz_blank  = r_sh_lz && (r_sh_hex[3] == 4'h0) &&
                    ((r_idx == 2'd3) || ((r_idx == 2'd2) && (r_sh_hex[2] == 4'h0)));
      w_seg       = f_decode(r_sh_hex[r_idx]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc     <= 16'd0;
         r_idx       <= 2'd0;
         r_sh_hex    <= '0;
         r_sh_dp_en  <= 4'h0;
         r_sh_lz     <= 1'b0;
         r_sh_blink  <= 1'b0;
         r_phase_on  <= 1'b1;
         r_phase_cnt <= 8'd0;
         r_an        <= 4'hF;
         r_sseg      <= 7'h7F;
         r_dp        <= 1'b1;
      end else begin
         r_presc <= w_slot_tick ? 16'd0 : r_presc + 16'd1;
         if (w_slot_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_scan_tick) begin
            r_sh_hex   <= {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
            r_sh_dp_en <= bus.dp_en;
            r_sh_lz    <= bus.blank_lz;
            r_sh_blink <= bus.blink;
         end
         // Phase follows the blink shadow in force, not the value being captured.
         if (!r_sh_blink) begin
            r_phase_cnt <= 8'd0;
            r_phase_on  <= 1'b1;
         end else if (w_scan_tick) begin
            if (r_phase_cnt == c_phase_max) begin
               r_phase_cnt <= 8'd0;
               r_phase_on  <= ~r_phase_on;
            end else begin
               r_phase_cnt <= r_phase_cnt + 8'd1;
            end
         end
         r_an   <= w_dark ? 4'hF : ~(4'b0001 << r_idx);
         r_sseg <= (w_dark || w_lz_blank) ? 7'h7F : w_seg;
         r_dp   <= w_dark ? 1'b1 : ~r_sh_dp_en[r_idx];
      end
   end

   assign bus.an   = r_an;
   assign bus.sseg = r_sseg;
   assign bus.dp   = r_dp;

endmodule
`default_nettype wire

// File: doc/ctl_disp_mux.md
CTL_DISP_MUX -- requirements
Module: ctl_disp_mux

Interface
REQ-001 Parameter DIV, default 65000: clk cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_CYC, default 64: cycles at the start of each slot with all anodes off; legal range 0..DIV-1.
REQ-003 Parameter BLINK_SCANS, default 128: full 4-digit scans per blink half-period; legal range 1..255.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 hex0, hex1, hex2, hex3  input  4 each  digit values; hex0 is rightmost, hex3 is leftmost; hex3/hex2 are the score digits.
REQ-007 dp_en  input  4  decimal-point enable per digit; bit i maps to digit i.
REQ-008 blank_lz  input  1  leading-zero blanking enable for hex3 and hex2.
REQ-009 blink  input  1  enable for whole-display blinking.
REQ-010 an  output  4  anode select, active-low, one-hot-low when driving.
REQ-011 sseg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal point, active-low.

Function
REQ-013 Prescaler counts 0..DIV-1 and wraps; the cycle with prescaler==DIV-1 is a slot tick.
REQ-014 2-bit digit index advances 0->1->2->3->0 on each slot tick.
REQ-015 On a slot tick that takes index 3->0, hex0..hex3, dp_en, blank_lz and blink are captured into shadow registers; decoding uses shadow values only, so there is no tearing mid-scan.
REQ-016 Inputs that change between capture points have no effect until the next 3->0 tick.
REQ-017 Blink phase counter counts 3->0 ticks modulo BLINK_SCANS; blink phase toggles when the count wraps.
REQ-018 Slot is dark when prescaler < BLANK_CYC, or when shadow blink=1 and blink phase=off; dark means an=4'b1111, sseg=7'h7F, dp=1.
REQ-019 Slot is lit otherwise: an bit[index]=0 and all other bits=1.
REQ-020 Decode (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-021 Leading-zero rule with shadow blank_lz=1:
- digit 3 blank (sseg=7'h7F) when hex3==0
- digit 2 blank when hex3==0 and hex2==0
- anode still asserted for a blanked digit
- digits 1 and 0 never blanked
REQ-022 dp=~dp_en[index] in a lit slot; dp=1 in a dark slot.
REQ-023 an, sseg and dp are registered; they reflect the index/prescaler state of the previous cycle (1-cycle latency) and change in the same cycle.
REQ-024 With shadow blink=0, the blink phase is forced to on, and the phase counter holds 0.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 While rst_n=0 at a posedge:
- prescaler=0, index=0
- shadows=0, blink phase=on, phase count=0
- an=4'b1111, sseg=7'h7F, dp=1
REQ-027 Reset asserted mid-slot or mid-scan takes effect at the next posedge, independent of current state.
REQ-028 After release, the first lit output is digit 0 at cycle BLANK_CYC+1, showing the reset shadows (digit "0", dp off).

Verification
REQ-029 Run with DIV=4, BLANK_CYC=1, BLINK_SCANS=2.
REQ-030 Scan: hex3..0=1,2,3,4, dp_en=0, blank_lz=0, after first capture ->
- an cycles 1110,1101,1011,0111, each lit 3 of 4 cycles
- sseg=7'h19,7'h30,7'h24,7'h79 respectively
REQ-031 Tear-free: change hex0 from 4 to 8 mid-scan -> digit 0 shows 7'h19 until the next 3->0 tick, then 7'h00.
REQ-032 Leading zeros: hex3=0, hex2=0, hex1=5, blank_lz=1 ->
- digit3 and digit2 sseg=7'h7F with anode low
- digit1 sseg=7'h12
- with hex2=7 instead, digit2 sseg=7'h78
REQ-033 Blink: blink=1 -> display alternates 2 full scans lit, 2 full scans dark (an=4'b1111); blink=0 -> lit continuously from the next capture.
REQ-034 Reset mid-scan at index 2 -> next cycle an=4'b1111, sseg=7'h7F, dp=1; digit 0 lit 2 cycles after release.
REQ-035 Decimal point: dp_en=4'b0100 -> dp=0 only while an=4'b1011 and lit.
